// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
//
// Shares a single-port, one-cycle-latency instruction ROM between the
// instruction-fetch port (IF) and a load/store port (LS). At most one request
// is granted per cycle. The granted byte address is checked. A misaligned or
// out-of-range address never reaches the ROM and gets an error response. A
// good address is issued to the ROM as a word address. Exactly one cycle after
// a grant, the response is routed back to the port that was granted.
//
// Parameters
//   ADDR_W      ROM word-address width (2^ADDR_W 32-bit words)
//   FIXED_PRIO  0 = round-robin between IF and LS, 1 = IF always wins a tie
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   if_req_i / if_addr_i           IF request and byte address
//   if_gnt_o                       IF accepted this cycle (combinational)
//   if_rvalid_o/if_rdata_o/if_err_o IF response, one cycle after if_gnt_o
//   ls_req_i / ls_addr_i           LS request and byte address
//   ls_gnt_o                       LS accepted this cycle (combinational)
//   ls_rvalid_o/ls_rdata_o/ls_err_o LS response, one cycle after ls_gnt_o
//   mem_en_o / mem_addr_o          ROM read enable and word address
//   mem_rdata_i                    ROM data, valid one cycle after mem_en_o
// -----------------------------------------------------------------------------
module rom_arbiter #(
  parameter int ADDR_W     = 10,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  output logic              if_err_o,

  input  logic              ls_req_i,
  input  logic [31:0]       ls_addr_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [31:0]       ls_rdata_o,
  output logic              ls_err_o,

  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i
);

  // Owner of the response in flight.
  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

  // Registered state.
  logic last_ls_q;   // round-robin pointer: 1 = LS was granted most recently
  logic pending_q;   // a response is due this cycle
  logic owner_q;     // port that the pending response belongs to
  logic err_q;       // the pending response is an error

  // Request-side combinational signals.
  logic        if_wins;
  logic        gnt_if;
  logic        gnt_ls;
  logic        gnt_any;
  logic [31:0] sel_addr;
  logic        addr_err;

  // Response-side combinational signals.
  logic resp_valid;

  // ---------------------------------------------------------------------------
  // Arbitration and address check
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a value on every path. Otherwise the
  // tool would have to remember an old value, and that infers a latch.
  always_comb begin
    // IF wins when it is alone, when priority is fixed, or when LS was served
    // last. While rst_n is low, both grants are forced off whatever is
    // requested.
    if_wins  = FIXED_PRIO || !ls_req_i || last_ls_q;
    gnt_if   = rst_n && if_req_i && if_wins;
    gnt_ls   = rst_n && ls_req_i && !(if_req_i && if_wins);
    gnt_any  = gnt_if || gnt_ls;

    sel_addr = gnt_ls ? ls_addr_i : if_addr_i;

    // Bits above the ROM's byte range must be zero. The shift form stays legal
    // even when ADDR_W+2 reaches the full 32-bit width.
    addr_err = (sel_addr[1:0] != 2'b00) ||
               ((sel_addr >> (ADDR_W + 2)) != 32'd0);

    mem_en_o   = gnt_any && !addr_err;
    mem_addr_o = mem_en_o ? sel_addr[ADDR_W+1:2] : '0;
  end

  assign if_gnt_o = gnt_if;
  assign ls_gnt_o = gnt_ls;

  // ---------------------------------------------------------------------------
  // Response tracking
  // ---------------------------------------------------------------------------
  // NOTE: registered state uses non-blocking assignments. Every flop then
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      owner_q   <= OWNER_IF;
      err_q     <= 1'b0;
      // "LS served last", so IF wins the first tie after reset.
      last_ls_q <= 1'b1;
    end else begin
      pending_q <= gnt_any;
      err_q     <= gnt_any && addr_err;
      if (gnt_any) begin
        owner_q   <= gnt_ls ? OWNER_LS : OWNER_IF;
        // The pointer moves only on a grant. Idle cycles keep the fairness
        // history.
        last_ls_q <= gnt_ls;
      end
    end
  end

  // A response is dropped as soon as reset is asserted. Gating here covers
  // the cycle in which the reset has not yet been clocked into pending_q.
  assign resp_valid = pending_q && rst_n;

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  always_comb begin
    if_rvalid_o = resp_valid && (owner_q == OWNER_IF);
    ls_rvalid_o = resp_valid && (owner_q == OWNER_LS);

    if_err_o    = if_rvalid_o && err_q;
    ls_err_o    = ls_rvalid_o && err_q;

    // An error response carries no data. Stale ROM output from an earlier
    // read must never reach a requester.
    if_rdata_o  = (if_rvalid_o && !err_q) ? mem_rdata_i : 32'd0;
    ls_rdata_o  = (ls_rvalid_o && !err_q) ? mem_rdata_i : 32'd0;
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_arbiter
//
// Directed bench for rom_arbiter. Instance "a" uses round-robin arbitration
// and instance "b" uses fixed IF priority. Both share a behavioural
// one-cycle-latency ROM image. Inputs change 1 time unit after a rising edge,
// and outputs are sampled on the following falling edge.
// -----------------------------------------------------------------------------
module tb_rom_arbiter;

  localparam int          ADDR_W = 10;
  localparam logic [31:0] W0     = 32'hC0DE_0000;
  localparam logic [31:0] W2     = 32'hC0DE_0002;
  localparam logic [31:0] W5     = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance a (round-robin).
  logic              a_if_req, a_if_gnt, a_if_rvalid, a_if_err;
  logic [31:0]       a_if_addr, a_if_rdata;
  logic              a_ls_req, a_ls_gnt, a_ls_rvalid, a_ls_err;
  logic [31:0]       a_ls_addr, a_ls_rdata;
  logic              a_mem_en;
  logic [ADDR_W-1:0] a_mem_addr;
  logic [31:0]       a_mem_rdata = '0;

  // Instance b (fixed IF priority).
  logic              b_if_req, b_if_gnt, b_if_rvalid, b_if_err;
  logic [31:0]       b_if_addr, b_if_rdata;
  logic              b_ls_req, b_ls_gnt, b_ls_rvalid, b_ls_err;
  logic [31:0]       b_ls_addr, b_ls_rdata;
  logic              b_mem_en;
  logic [ADDR_W-1:0] b_mem_addr;
  logic [31:0]       b_mem_rdata = '0;

  logic [31:0] rom [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  rom_arbiter #(.ADDR_W(ADDR_W), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(a_if_req), .if_addr_i(a_if_addr), .if_gnt_o(a_if_gnt),
    .if_rvalid_o(a_if_rvalid), .if_rdata_o(a_if_rdata), .if_err_o(a_if_err),
    .ls_req_i(a_ls_req), .ls_addr_i(a_ls_addr), .ls_gnt_o(a_ls_gnt),
    .ls_rvalid_o(a_ls_rvalid), .ls_rdata_o(a_ls_rdata), .ls_err_o(a_ls_err),
    .mem_en_o(a_mem_en), .mem_addr_o(a_mem_addr), .mem_rdata_i(a_mem_rdata)
  );

  rom_arbiter #(.ADDR_W(ADDR_W), .FIXED_PRIO(1'b1)) u_fixed (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_gnt_o(b_if_gnt),
    .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata), .if_err_o(b_if_err),
    .ls_req_i(b_ls_req), .ls_addr_i(b_ls_addr), .ls_gnt_o(b_ls_gnt),
    .ls_rvalid_o(b_ls_rvalid), .ls_rdata_o(b_ls_rdata), .ls_err_o(b_ls_err),
    .mem_en_o(b_mem_en), .mem_addr_o(b_mem_addr), .mem_rdata_i(b_mem_rdata)
  );

  // ROM macro model: registered output that holds its value when not enabled.
  always @(posedge clk) begin
    if (a_mem_en) a_mem_rdata <= rom[a_mem_addr];
    if (b_mem_en) b_mem_rdata <= rom[b_mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = W0 + 32'(i);
    rom[5] = W5;

    // Reset with a live IF request: grants and enable must stay low.
    rst_n     = 1'b0;
    a_if_req  = 1'b1; a_if_addr = 32'h0; a_ls_req = 1'b0; a_ls_addr = 32'h0;
    b_if_req  = 1'b1; b_if_addr = 32'h0; b_ls_req = 1'b0; b_ls_addr = 32'h0;
    mid();
    check("rst_a_if_gnt", a_if_gnt, 1'b0);
    check("rst_a_mem_en", a_mem_en, 1'b0);
    check("rst_b_if_gnt", b_if_gnt, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // Continuous tie: a alternates IF/LS starting with IF; b always picks IF
    // and grants LS only once IF drops.
    for (int k = 0; k < 7; k++) begin
      a_if_req = (k < 6); a_ls_req = (k < 6); a_if_addr = 32'h0; a_ls_addr = 32'h8;
      b_if_req = (k < 4); b_ls_req = (k < 5); b_if_addr = 32'h0; b_ls_addr = 32'h8;
      mid();
      if (k < 6) begin
        check($sformatf("rr_if_gnt_%0d", k), a_if_gnt, (k % 2) == 0);
        check($sformatf("rr_ls_gnt_%0d", k), a_ls_gnt, (k % 2) == 1);
        check($sformatf("rr_mem_addr_%0d", k), a_mem_addr, (k % 2) ? 2 : 0);
      end
      if (k == 0) begin
        check("rst_a_if_rvalid", a_if_rvalid, 1'b0);
        check("rst_a_ls_rvalid", a_ls_rvalid, 1'b0);
      end else begin
        check($sformatf("rr_if_rvalid_%0d", k), a_if_rvalid, ((k - 1) % 2) == 0);
        check($sformatf("rr_ls_rvalid_%0d", k), a_ls_rvalid, ((k - 1) % 2) == 1);
        check($sformatf("rr_if_rdata_%0d", k), a_if_rdata, ((k - 1) % 2) ? 32'h0 : W0);
        check($sformatf("rr_ls_rdata_%0d", k), a_ls_rdata, ((k - 1) % 2) ? W2 : 32'h0);
      end
      if (k < 5) begin
        check($sformatf("fx_if_gnt_%0d", k), b_if_gnt, k < 4);
        check($sformatf("fx_ls_gnt_%0d", k), b_ls_gnt, k == 4);
      end
      if (k == 5) begin
        check("fx_ls_rvalid", b_ls_rvalid, 1'b1);
        check("fx_ls_rdata", b_ls_rdata, W2);
        check("fx_if_rvalid", b_if_rvalid, 1'b0);
      end
      tick();
    end

    // Single IF read of word 5.
    a_if_req = 1'b1; a_if_addr = 32'h14;
    mid();
    check("if_gnt", a_if_gnt, 1'b1);
    check("if_ls_gnt", a_ls_gnt, 1'b0);
    check("if_mem_en", a_mem_en, 1'b1);
    check("if_mem_addr", a_mem_addr, 5);
    tick();

    // Misaligned LS request, granted while the IF response returns.
    a_if_req = 1'b0; a_ls_req = 1'b1; a_ls_addr = 32'h6;
    mid();
    check("if_rvalid", a_if_rvalid, 1'b1);
    check("if_rdata", a_if_rdata, W5);
    check("if_err", a_if_err, 1'b0);
    check("if_other_rvalid", a_ls_rvalid, 1'b0);
    check("mis_ls_gnt", a_ls_gnt, 1'b1);
    check("mis_mem_en", a_mem_en, 1'b0);
    check("mis_mem_addr", a_mem_addr, 0);
    tick();

    // Out-of-range LS request while the misaligned response returns.
    a_ls_addr = 32'h1000;
    mid();
    check("mis_rvalid", a_ls_rvalid, 1'b1);
    check("mis_err", a_ls_err, 1'b1);
    check("mis_rdata", a_ls_rdata, 32'h0);
    check("mis_if_rvalid", a_if_rvalid, 1'b0);
    check("oor_ls_gnt", a_ls_gnt, 1'b1);
    check("oor_mem_en", a_mem_en, 1'b0);
    tick();

    a_ls_req = 1'b0;
    mid();
    check("oor_rvalid", a_ls_rvalid, 1'b1);
    check("oor_err", a_ls_err, 1'b1);
    check("oor_rdata", a_ls_rdata, 32'h0);
    tick();

    // Back-to-back IF reads of words 0, 1, 2.
    for (int j = 0; j < 4; j++) begin
      a_if_req = (j < 3); a_if_addr = 32'(4 * j);
      mid();
      if (j < 3) begin
        check($sformatf("b2b_gnt_%0d", j), a_if_gnt, 1'b1);
        check($sformatf("b2b_mem_addr_%0d", j), a_mem_addr, j);
      end
      if (j > 0) begin
        check($sformatf("b2b_rvalid_%0d", j), a_if_rvalid, 1'b1);
        check($sformatf("b2b_rdata_%0d", j), a_if_rdata, W0 + 32'(j - 1));
        check($sformatf("b2b_err_%0d", j), a_if_err, 1'b0);
      end
      tick();
    end

    // Reset asserted in the response cycle drops the response.
    a_if_req = 1'b1; a_if_addr = 32'h4;
    mid();
    check("rmid_gnt", a_if_gnt, 1'b1);
    tick();
    a_if_req = 1'b0; rst_n = 1'b0;
    mid();
    check("rmid_rvalid_drop", a_if_rvalid, 1'b0);
    tick();
    rst_n = 1'b1;
    mid();
    check("rmid_rvalid_after", a_if_rvalid, 1'b0);
    tick();

    // The first tie after reset goes to IF, although IF was served last before.
    a_if_req = 1'b1; a_ls_req = 1'b1; a_if_addr = 32'h0; a_ls_addr = 32'h8;
    mid();
    check("post_rst_if_gnt", a_if_gnt, 1'b1);
    check("post_rst_ls_gnt", a_ls_gnt, 1'b0);
    tick();
    a_if_req = 1'b0; a_ls_req = 1'b0;
    mid();
    check("post_rst_rvalid", a_if_rvalid, 1'b1);
    check("post_rst_rdata", a_if_rdata, W0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
